// File: rtl/cfg_slv_pkg.sv
// Shared types and constants for the AXI-Lite configuration responder.
package cfg_slv_pkg;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_ACK  = 1'b1
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } r_state_e;

   localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

   // The optional status register lives directly above the last config register.
   function automatic int unsigned status_slot_idx(input int unsigned num_regs);
      return num_regs;
   endfunction

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/cfg_slv_if.sv
// AXI-Lite bus bundle between the config controller (master) and a responder (slave).
interface cfg_slv_if;

   logic        axi_awvalid;
   logic [14:0] axi_awaddr;
   logic        axi_awready;
   logic        axi_wvalid;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wready;
   logic        axi_arvalid;
   logic [14:0] axi_araddr;
   logic        axi_arready;
   logic        axi_rvalid;
   logic [31:0] axi_rdata;
   logic        axi_rready;

   modport master (
      output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
      output axi_arvalid, axi_araddr, axi_rready,
      input  axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
   );

   modport slave (
      input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
      input  axi_arvalid, axi_araddr, axi_rready,
      output axi_awready, axi_wready, axi_arready, axi_rvalid, axi_rdata
   );

endinterface

// File: rtl/cfg_slv_regfile.sv
// Byte-writable configuration register bank with write pulses and read mux.
// CFG_SLV_STATUS_EN adds a sticky write-1-to-clear status register and irq.
module cfg_slv_regfile
   import cfg_slv_pkg::*;
#(
   parameter int pNUM_REGS = 8,
   parameter int IDX_W     = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [IDX_W-1:0]          wr_idx,
   input  logic [31:0]               wr_data,
   input  logic [3:0]                wr_strb,
   input  logic [IDX_W-1:0]          rd_idx,
   output logic [31:0]               rd_data,
   output logic [pNUM_REGS*32-1:0]   reg_out,
   output logic [pNUM_REGS-1:0]      reg_wr_pulse
`ifdef CFG_SLV_STATUS_EN
   ,
   input  logic                      st_wr_en,
   input  logic [31:0]               status_in,
   output logic                      irq
`endif
);

   logic [31:0]          regs_q [pNUM_REGS];
   logic [31:0]          regs_d [pNUM_REGS];
   logic [pNUM_REGS-1:0] pulse_q;
   logic [pNUM_REGS-1:0] pulse_d;

   always_comb begin
      pulse_d = '0;
      for (int k = 0; k < pNUM_REGS; k++) begin
         regs_d[k] = regs_q[k];
         if (wr_en && (wr_idx == IDX_W'(k)) && (wr_strb != 4'h0)) begin
            regs_d[k]  = (regs_q[k] & ~strb_mask(wr_strb)) | (wr_data & strb_mask(wr_strb));
            pulse_d[k] = 1'b1;
         end else begin
            pulse_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < pNUM_REGS; k++) begin
            regs_q[k] <= 32'h0;
         end
         pulse_q <= '0;
      end else begin
         for (int k = 0; k < pNUM_REGS; k++) begin
            regs_q[k] <= regs_d[k];
         end
         pulse_q <= pulse_d;
      end
   end

`ifdef CFG_SLV_STATUS_EN
   localparam logic [IDX_W-1:0] ST_IDX = IDX_W'(status_slot_idx(pNUM_REGS));

   logic [31:0] status_q;
   logic [31:0] status_d;
   logic        irq_q;
   logic        irq_d;

   // A new event on the same bit as a clear keeps the bit set.
   always_comb begin
      status_d = (status_q & ~(st_wr_en ? (wr_data & strb_mask(wr_strb)) : 32'h0)) | status_in;
      irq_d    = |status_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= 32'h0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= status_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

   always_comb begin
      rd_data = 32'h0;
      reg_out = '0;
      for (int k = 0; k < pNUM_REGS; k++) begin
         rd_data            = rd_data | ((rd_idx == IDX_W'(k)) ? regs_q[k] : 32'h0);
         reg_out[32*k +: 32] = regs_q[k];
      end
`ifdef CFG_SLV_STATUS_EN
      rd_data = rd_data | ((rd_idx == ST_IDX) ? status_q : 32'h0);
`endif
   end

   assign reg_wr_pulse = pulse_q;

endmodule

// File: rtl/axil_cfg_slave.sv
// AXI-Lite configuration responder: write/read handshake FSMs and offset decode.
// Optional status register and irq are enabled with CFG_SLV_STATUS_EN.
module axil_cfg_slave
   import cfg_slv_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int pNUM_REGS   = 8
) (
   input  logic                     axi_clk,
   input  logic                     axi_reset_n,
   input  logic                     cc_enable,
   cfg_slv_if.slave                 bus,
   output logic [pNUM_REGS*32-1:0]  reg_out,
   output logic [pNUM_REGS-1:0]     reg_wr_pulse
`ifdef CFG_SLV_STATUS_EN
   ,
   input  logic [31:0]              status_in,
   output logic                     irq
`endif
);

   localparam int IDX_W = pADDR_WIDTH - 2;

   w_state_e               w_state_q, w_state_d;
   logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
   logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]             wstrb_q, wstrb_d;
   r_state_e               r_state_q, r_state_d;
   logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
   logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;

   logic        reg_wr_en_s;
   logic        rd_map_s;
   logic [31:0] rf_rdata_s;
   logic        unused_s;

   assign unused_s = ^{bus.axi_awaddr[14:pADDR_WIDTH], bus.axi_awaddr[1:0],
                       bus.axi_araddr[14:pADDR_WIDTH], bus.axi_araddr[1:0]};

`ifdef CFG_SLV_STATUS_EN
   localparam logic [IDX_W-1:0] ST_IDX = IDX_W'(status_slot_idx(pNUM_REGS));
   logic st_wr_en_s;
`endif

   always_comb begin
      reg_wr_en_s = (w_state_q == W_ACK) && (wr_idx_q < IDX_W'(pNUM_REGS));
      rd_map_s    = (rd_idx_q < IDX_W'(pNUM_REGS));
`ifdef CFG_SLV_STATUS_EN
      st_wr_en_s  = (w_state_q == W_ACK) && (wr_idx_q == ST_IDX);
      rd_map_s    = rd_map_s || (rd_idx_q == ST_IDX);
`endif
   end

   always_comb begin
      w_state_d = w_state_q;
      wr_idx_d  = wr_idx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      case (w_state_q)
         W_IDLE: begin
            if (cc_enable && bus.axi_awvalid && bus.axi_wvalid) begin
               w_state_d = W_ACK;
               wr_idx_d  = bus.axi_awaddr[pADDR_WIDTH-1:2];
               wdata_d   = bus.axi_wdata;
               wstrb_d   = bus.axi_wstrb;
            end else begin
               w_state_d = W_IDLE;
            end
         end
         W_ACK:   w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // rdata is loaded once on entry to R_DATA so the same-edge write is not seen.
   always_comb begin
      r_state_d = r_state_q;
      rd_idx_d  = rd_idx_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (cc_enable && bus.axi_arvalid) begin
               r_state_d = R_ADDR;
               rd_idx_d  = bus.axi_araddr[pADDR_WIDTH-1:2];
            end else begin
               r_state_d = R_IDLE;
            end
         end
         R_ADDR: begin
            r_state_d = R_DATA;
            rdata_d   = rd_map_s ? rf_rdata_s : ERR_RDATA;
         end
         R_DATA: begin
            if (bus.axi_rready) begin
               r_state_d = R_IDLE;
               rdata_d   = 32'h0;
            end else begin
               r_state_d = R_DATA;
            end
         end
         default: begin
            r_state_d = R_IDLE;
            rdata_d   = 32'h0;
         end
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         w_state_q <= W_IDLE;
         wr_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= 4'h0;
         r_state_q <= R_IDLE;
         rd_idx_q  <= '0;
         rdata_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         wr_idx_q  <= wr_idx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         r_state_q <= r_state_d;
         rd_idx_q  <= rd_idx_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.axi_awready = (w_state_q == W_ACK);
   assign bus.axi_wready  = (w_state_q == W_ACK);
   assign bus.axi_arready = (r_state_q == R_ADDR);
   assign bus.axi_rvalid  = (r_state_q == R_DATA);
   assign bus.axi_rdata   = rdata_q;

   cfg_slv_regfile #(
      .pNUM_REGS (pNUM_REGS),
      .IDX_W     (IDX_W)
   ) u_regfile (
      .clk          (axi_clk),
      .rst_n        (axi_reset_n),
      .wr_en        (reg_wr_en_s),
      .wr_idx       (wr_idx_q),
      .wr_data      (wdata_q),
      .wr_strb      (wstrb_q),
      .rd_idx       (rd_idx_q),
      .rd_data      (rf_rdata_s),
      .reg_out      (reg_out),
      .reg_wr_pulse (reg_wr_pulse)
`ifdef CFG_SLV_STATUS_EN
      ,
      .st_wr_en     (st_wr_en_s),
      .status_in    (status_in),
      .irq          (irq)
`endif
   );

endmodule

// File: tb/tb_axil_cfg_slave.sv
// Directed self-checking bench for axil_cfg_slave (pNUM_REGS = 8).
module tb_axil_cfg_slave;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cc_en = 1'b0;
   logic [255:0] reg_out;
   logic [7:0]   pulse;
   int           tests_run = 0;
   int           tests_failed = 0;
   logic [31:0]  rd_val;
   bit           rd_ok;
`ifdef CFG_SLV_STATUS_EN
   logic [31:0]  status_in = 32'h0;
   logic         irq;
`endif

   cfg_slv_if bus ();

   axil_cfg_slave dut (
      .axi_clk      (clk),
      .axi_reset_n  (rst_n),
      .cc_enable    (cc_en),
      .bus          (bus),
      .reg_out      (reg_out),
      .reg_wr_pulse (pulse)
`ifdef CFG_SLV_STATUS_EN
      ,
      .status_in    (status_in),
      .irq          (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus;
      bus.axi_awvalid = 1'b0;
      bus.axi_awaddr  = 15'h0;
      bus.axi_wvalid  = 1'b0;
      bus.axi_wdata   = 32'h0;
      bus.axi_wstrb   = 4'h0;
      bus.axi_arvalid = 1'b0;
      bus.axi_araddr  = 15'h0;
   endtask

   task automatic set_wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.axi_awvalid = 1'b1;
      bus.axi_awaddr  = a;
      bus.axi_wvalid  = 1'b1;
      bus.axi_wdata   = d;
      bus.axi_wstrb   = s;
   endtask

   // Fixed-latency write: ends one sample after the commit edge.
   task automatic wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
      set_wr(a, d, s);
      tick;
      idle_bus;
      tick;
   endtask

   task automatic rd(input logic [14:0] a, output logic [31:0] d, output bit ok);
      int n;
      bus.axi_arvalid = 1'b1;
      bus.axi_araddr  = a;
      bus.axi_rready  = 1'b1;
      tick;
      bus.axi_arvalid = 1'b0;
      ok = 1'b0;
      d  = 32'h0;
      n  = 0;
      while (!ok && n < 8) begin
         if (bus.axi_rvalid) begin
            d  = bus.axi_rdata;
            ok = 1'b1;
         end else begin
            tick;
            n++;
         end
      end
      tick;
      bus.axi_rready = 1'b0;
   endtask

   task automatic test_reset;
      idle_bus;
      bus.axi_rready = 1'b0;
      cc_en = 1'b1;
      repeat (3) tick;
      tests_run++;
      if ({bus.axi_awready, bus.axi_wready, bus.axi_arready, bus.axi_rvalid, bus.axi_rdata, pulse} !== 44'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h, expected 0", {bus.axi_awready, bus.axi_wready, bus.axi_arready, bus.axi_rvalid, bus.axi_rdata, pulse});
      end
      tests_run++;
      if (reg_out !== 256'h0) begin
         tests_failed++;
         $display("FAIL reset_reg_out: got %h, expected 0", reg_out);
      end
      rst_n = 1'b1;
      tick;
      tests_run++;
      if ({bus.axi_awready, bus.axi_wready, bus.axi_arready, bus.axi_rvalid} !== 4'h0) begin
         tests_failed++;
         $display("FAIL post_reset_idle: got %b, expected 0000", {bus.axi_awready, bus.axi_wready, bus.axi_arready, bus.axi_rvalid});
      end
   endtask

   task automatic test_write_read;
      set_wr(15'h004, 32'h1234_5678, 4'hF);
      tick;
      tests_run++;
      if ({bus.axi_awready, bus.axi_wready, reg_out[63:32]} !== {2'b11, 32'h0}) begin
         tests_failed++;
         $display("FAIL wr_cycle1: got rdy=%b reg1=%h, expected rdy=11 reg1=0", {bus.axi_awready, bus.axi_wready}, reg_out[63:32]);
      end
      idle_bus;
      tick;
      tests_run++;
      if ({bus.axi_awready, bus.axi_wready, pulse, reg_out[63:32]} !== {2'b00, 8'h02, 32'h1234_5678}) begin
         tests_failed++;
         $display("FAIL wr_cycle2: got rdy=%b pulse=%h reg1=%h, expected 00 02 12345678", {bus.axi_awready, bus.axi_wready}, pulse, reg_out[63:32]);
      end
      tick;
      tests_run++;
      if (pulse !== 8'h00) begin
         tests_failed++;
         $display("FAIL wr_pulse_width: got %h, expected 00", pulse);
      end
      bus.axi_arvalid = 1'b1;
      bus.axi_araddr  = 15'h004;
      tick;
      tests_run++;
      if ({bus.axi_arready, bus.axi_rvalid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL rd_cycle1: got %b, expected 10", {bus.axi_arready, bus.axi_rvalid});
      end
      bus.axi_arvalid = 1'b0;
      tick;
      tests_run++;
      if ({bus.axi_rvalid, bus.axi_rdata} !== {1'b1, 32'h1234_5678}) begin
         tests_failed++;
         $display("FAIL rd_cycle2: got v=%b d=%h, expected v=1 d=12345678", bus.axi_rvalid, bus.axi_rdata);
      end
      bus.axi_rready = 1'b1;
      tick;
      bus.axi_rready = 1'b0;
      tests_run++;
      if ({bus.axi_rvalid, bus.axi_rdata} !== 33'h0) begin
         tests_failed++;
         $display("FAIL rd_done: got v=%b d=%h, expected 0", bus.axi_rvalid, bus.axi_rdata);
      end
   endtask

   task automatic test_strobe;
      wr(15'h004, 32'hAABB_CCDD, 4'h2);
      tests_run++;
      if ({reg_out[63:32], pulse} !== {32'h1234_CC78, 8'h02}) begin
         tests_failed++;
         $display("FAIL strb_byte1: got reg1=%h pulse=%h, expected 1234cc78 02", reg_out[63:32], pulse);
      end
      wr(15'h004, 32'hFFFF_FFFF, 4'h0);
      tests_run++;
      if ({reg_out[63:32], pulse} !== {32'h1234_CC78, 8'h00}) begin
         tests_failed++;
         $display("FAIL strb_zero: got reg1=%h pulse=%h, expected 1234cc78 00", reg_out[63:32], pulse);
      end
      wr(15'h01F, 32'hCAFE_F00D, 4'hF);
      tests_run++;
      if ({reg_out[255:224], pulse} !== {32'hCAFE_F00D, 8'h80}) begin
         tests_failed++;
         $display("FAIL wr_last_reg: got reg7=%h pulse=%h, expected cafef00d 80", reg_out[255:224], pulse);
      end
      wr(15'h7000, 32'h0000_00A5, 4'h1);
      tests_run++;
      if ({reg_out[31:0], pulse} !== {32'h0000_00A5, 8'h01}) begin
         tests_failed++;
         $display("FAIL wr_high_addr_ignored: got reg0=%h pulse=%h, expected 000000a5 01", reg_out[31:0], pulse);
      end
      wr(15'h0FC, 32'hDEAD_BEEF, 4'hF);
      tests_run++;
      if ({reg_out, pulse} !== {32'hCAFE_F00D, 160'h0, 32'h1234_CC78, 32'h0000_00A5, 8'h00}) begin
         tests_failed++;
         $display("FAIL wr_unmapped: got reg_out=%h pulse=%h", reg_out, pulse);
      end
   endtask

   task automatic test_unmapped_read;
      bus.axi_arvalid = 1'b1;
      bus.axi_araddr  = 15'h0FC;
      bus.axi_rready  = 1'b0;
      tick;
      bus.axi_arvalid = 1'b0;
      tick;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if ({bus.axi_rvalid, bus.axi_rdata} !== {1'b1, 32'hFFFF_FFFF}) begin
            tests_failed++;
            $display("FAIL rd_unmapped_hold%0d: got v=%b d=%h, expected 1 ffffffff", i, bus.axi_rvalid, bus.axi_rdata);
         end
         tick;
      end
      bus.axi_rready = 1'b1;
      tick;
      bus.axi_rready = 1'b0;
      tests_run++;
      if ({bus.axi_rvalid, bus.axi_arready, bus.axi_rdata} !== 34'h0) begin
         tests_failed++;
         $display("FAIL rd_unmapped_release: got v=%b ar=%b d=%h, expected 0", bus.axi_rvalid, bus.axi_arready, bus.axi_rdata);
      end
      rd(15'h01C, rd_val, rd_ok);
      tests_run++;
      if (!rd_ok || rd_val !== 32'hCAFE_F00D) begin
         tests_failed++;
         $display("FAIL rd_last_reg: got %h ok=%0d, expected cafef00d", rd_val, rd_ok);
      end
`ifndef CFG_SLV_STATUS_EN
      rd(15'h020, rd_val, rd_ok);
      tests_run++;
      if (!rd_ok || rd_val !== 32'hFFFF_FFFF) begin
         tests_failed++;
         $display("FAIL rd_first_unmapped: got %h ok=%0d, expected ffffffff", rd_val, rd_ok);
      end
`endif
   endtask

   task automatic test_wait_aw;
      set_wr(15'h008, 32'h5A5A_5A5A, 4'hF);
      bus.axi_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         tests_run++;
         if ({bus.axi_awready, bus.axi_wready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL aw_only_wait%0d: got %b, expected 00", i, {bus.axi_awready, bus.axi_wready});
         end
      end
      bus.axi_wvalid = 1'b1;
      tick;
      tests_run++;
      if ({bus.axi_awready, bus.axi_wready} !== 2'b11) begin
         tests_failed++;
         $display("FAIL aw_then_w_ready: got %b, expected 11", {bus.axi_awready, bus.axi_wready});
      end
      idle_bus;
      tick;
      tests_run++;
      if (reg_out[95:64] !== 32'h5A5A_5A5A) begin
         tests_failed++;
         $display("FAIL aw_then_w_data: got %h, expected 5a5a5a5a", reg_out[95:64]);
      end
   endtask

   task automatic test_back_to_back;
      set_wr(15'h00C, 32'h1111_1111, 4'hF);
      tick;
      set_wr(15'h010, 32'h2222_2222, 4'hF);
      tick;
      tests_run++;
      if ({bus.axi_awready, reg_out[127:96]} !== {1'b0, 32'h1111_1111}) begin
         tests_failed++;
         $display("FAIL b2b_first: got rdy=%b reg3=%h, expected 0 11111111", bus.axi_awready, reg_out[127:96]);
      end
      tick;
      tests_run++;
      if ({bus.axi_awready, bus.axi_wready} !== 2'b11) begin
         tests_failed++;
         $display("FAIL b2b_second_ready: got %b, expected 11", {bus.axi_awready, bus.axi_wready});
      end
      idle_bus;
      tick;
      tests_run++;
      if ({reg_out[159:128], pulse} !== {32'h2222_2222, 8'h10}) begin
         tests_failed++;
         $display("FAIL b2b_second: got reg4=%h pulse=%h, expected 22222222 10", reg_out[159:128], pulse);
      end
   endtask

   task automatic test_same_edge;
      set_wr(15'h008, 32'h0BAD_CAFE, 4'hF);
      bus.axi_arvalid = 1'b1;
      bus.axi_araddr  = 15'h008;
      bus.axi_rready  = 1'b1;
      tick;
      tests_run++;
      if ({bus.axi_awready, bus.axi_wready, bus.axi_arready} !== 3'b111) begin
         tests_failed++;
         $display("FAIL same_edge_ready: got %b, expected 111", {bus.axi_awready, bus.axi_wready, bus.axi_arready});
      end
      idle_bus;
      tick;
      tests_run++;
      if ({bus.axi_rvalid, bus.axi_rdata, reg_out[95:64]} !== {1'b1, 32'h5A5A_5A5A, 32'h0BAD_CAFE}) begin
         tests_failed++;
         $display("FAIL same_edge_old_value: got v=%b d=%h reg2=%h, expected 1 5a5a5a5a 0badcafe", bus.axi_rvalid, bus.axi_rdata, reg_out[95:64]);
      end
      tick;
      bus.axi_rready = 1'b0;
   endtask

   task automatic test_cc_enable;
      cc_en = 1'b0;
      set_wr(15'h004, 32'h0, 4'hF);
      bus.axi_arvalid = 1'b1;
      bus.axi_araddr  = 15'h004;
      for (int i = 0; i < 3; i++) begin
         tick;
         tests_run++;
         if ({bus.axi_awready, bus.axi_wready, bus.axi_arready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL cc_disabled%0d: got %b, expected 000", i, {bus.axi_awready, bus.axi_wready, bus.axi_arready});
         end
      end
      idle_bus;
      cc_en = 1'b1;
      bus.axi_arvalid = 1'b1;
      bus.axi_araddr  = 15'h004;
      tick;
      cc_en = 1'b0;
      bus.axi_arvalid = 1'b0;
      tick;
      tests_run++;
      if ({bus.axi_rvalid, bus.axi_rdata} !== {1'b1, 32'h1234_CC78}) begin
         tests_failed++;
         $display("FAIL cc_drop_midread: got v=%b d=%h, expected 1 1234cc78", bus.axi_rvalid, bus.axi_rdata);
      end
      bus.axi_rready = 1'b1;
      tick;
      bus.axi_rready = 1'b0;
      cc_en = 1'b1;
   endtask

`ifdef CFG_SLV_STATUS_EN
   task automatic test_status;
      status_in = 32'h8;
      tick;
      status_in = 32'h0;
      tests_run++;
      if (irq !== 1'b1) begin
         tests_failed++;
         $display("FAIL status_irq_set: got %b, expected 1", irq);
      end
      rd(15'h020, rd_val, rd_ok);
      tests_run++;
      if (!rd_ok || rd_val !== 32'h8) begin
         tests_failed++;
         $display("FAIL status_read: got %h ok=%0d, expected 00000008", rd_val, rd_ok);
      end
      set_wr(15'h020, 32'h8, 4'h1);
      tick;
      idle_bus;
      status_in = 32'h8;
      tick;
      status_in = 32'h0;
      rd(15'h020, rd_val, rd_ok);
      tests_run++;
      if (!rd_ok || rd_val !== 32'h8 || irq !== 1'b1) begin
         tests_failed++;
         $display("FAIL status_set_wins: got %h irq=%b, expected 00000008 irq=1", rd_val, irq);
      end
      wr(15'h020, 32'h8, 4'h1);
      rd(15'h020, rd_val, rd_ok);
      tests_run++;
      if (!rd_ok || rd_val !== 32'h0 || irq !== 1'b0) begin
         tests_failed++;
         $display("FAIL status_w1c: got %h irq=%b, expected 00000000 irq=0", rd_val, irq);
      end
   endtask
`endif

   task automatic test_reset_mid;
      bus.axi_arvalid = 1'b1;
      bus.axi_araddr  = 15'h004;
      bus.axi_rready  = 1'b0;
      tick;
      bus.axi_arvalid = 1'b0;
      tick;
      tests_run++;
      if (bus.axi_rvalid !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_rst_setup: got rvalid=%b, expected 1", bus.axi_rvalid);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus.axi_rvalid, bus.axi_rdata, reg_out} !== 289'h0) begin
         tests_failed++;
         $display("FAIL mid_rst_abort: got v=%b d=%h reg_out=%h, expected 0", bus.axi_rvalid, bus.axi_rdata, reg_out);
      end
      #2;
      rst_n = 1'b1;
      cc_en = 1'b0;
      bus.axi_arvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         tests_run++;
         if (bus.axi_arready !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_rst_cc_low%0d: got arready=%b, expected 0", i, bus.axi_arready);
         end
      end
      idle_bus;
      cc_en = 1'b1;
      rd(15'h004, rd_val, rd_ok);
      tests_run++;
      if (!rd_ok || rd_val !== 32'h0) begin
         tests_failed++;
         $display("FAIL post_rst_reg1: got %h ok=%0d, expected 00000000", rd_val, rd_ok);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_write_read;
      test_strobe;
      test_unmapped_read;
      test_wait_aw;
      test_back_to_back;
      test_same_edge;
      test_cc_enable;
`ifdef CFG_SLV_STATUS_EN
      test_status;
`endif
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/axil_cfg_slave.md
# axil_cfg_slave

AXI-Lite configuration responder that sits on the target side of the config controller's 15-bit AXI-Lite master bus, one instance per subsystem. It terminates write and read transactions selected by its `cc_enable` target-select line and holds a bank of byte-writable 32-bit configuration registers that drive the subsystem. Unmapped offsets are acknowledged normally: writes are dropped and reads return the error pattern 0xFFFFFFFF. The block matches the master's handshake: single-cycle joint awready/wready, and rvalid held until rready.

## Interface
Parameters:
- pADDR_WIDTH, 12, byte-offset bits decoded inside the target window
- pDATA_WIDTH, 32, data width; only 32 is supported
- pNUM_REGS, 8, number of configuration registers (1..64)

Ports:
- axi_clk  in  1  single clock for all logic
- axi_reset_n  in  1  asynchronous, active-low reset
- cc_enable  in  1  target select from the config controller; samples new transactions only
- axi_awvalid  in  1  write address valid
- axi_awaddr  in  15  write address; bits [14:pADDR_WIDTH] ignored
- axi_awready  out  1  write address accept
- axi_wvalid  in  1  write data valid
- axi_wdata  in  32  write data
- axi_wstrb  in  4  byte enables
- axi_wready  out  1  write data accept
- axi_arvalid  in  1  read address valid
- axi_araddr  in  15  read address
- axi_arready  out  1  read address accept
- axi_rvalid  out  1  read data valid
- axi_rdata  out  32  read data
- axi_rready  in  1  read data accept
- reg_out  out  pNUM_REGS*32  concatenated register contents; reg k is at bits [32k+31:32k]
- reg_wr_pulse  out  pNUM_REGS  one-cycle pulse on the cycle after a committed write to reg k

## Operation
- Decode: idx = offset[pADDR_WIDTH-1:2]. offset[1:0] is ignored.
  - idx < pNUM_REGS is mapped.
  - Every other idx is unmapped, except the status slot when CFG_SLV_STATUS_EN is defined.
- Write FSM, states W_IDLE and W_ACK:
  - W_IDLE→W_ACK when cc_enable, awvalid and wvalid are all high in the same cycle. Address, data and strobes are captured at that edge.
  - If only one of awvalid/wvalid is high, the FSM stays in W_IDLE and waits.
  - In W_ACK, awready and wready are both 1 for exactly one cycle. The register commit occurs at the W_ACK→W_IDLE edge.
  - Each byte is written only where its wstrb bit is 1. wstrb = 0 commits nothing and raises no pulse.
  - Writes to unmapped offsets are acknowledged, dropped, and raise no pulse.
- Read FSM, states R_IDLE, R_ADDR and R_DATA:
  - R_IDLE→R_ADDR when cc_enable and arvalid are high. araddr is captured at that edge.
  - R_ADDR: arready = 1 for one cycle. rdata is sampled at the end of R_ADDR.
  - R_DATA: rvalid = 1 and rdata is held stable until the cycle in which rready = 1, then the FSM returns to R_IDLE.
  - Unmapped reads return 0xFFFFFFFF.
- The two FSMs are independent and may be busy at the same time.
  - Read and write committing on the same edge to the same register: the read returns the pre-write value.
- Once started, a transaction completes regardless of cc_enable. A deasserted cc_enable blocks only new starts.
- Back-to-back: a new transaction may start the cycle after the FSM returns to its IDLE state.

## Timing
- Reset values: every register is 0. All outputs are 0, including awready, wready, arready, rvalid, rdata, reg_wr_pulse and reg_out.
- Asserting axi_reset_n low mid-transaction aborts it immediately. Both FSMs return to IDLE and all ready/valid outputs drop in the same cycle.
- Write: valid inputs sampled at cycle 0; awready/wready high in cycle 1; reg_out updated and reg_wr_pulse high in cycle 2.
- Read: arvalid sampled at cycle 0; arready high in cycle 1; rvalid high from cycle 2. Minimum read latency is 2 cycles.
- rdata is 0 whenever rvalid = 0.

## Configuration
- CFG_SLV_STATUS_EN defined:
  - Adds a sticky status register at idx = pNUM_REGS.
  - Adds ports status_in (in, 32) and irq (out, 1).
  - Each status bit is set by a high on the matching status_in bit.
  - Status bits are cleared by writing 1 to them (write-1-to-clear, byte-strobed).
  - When set and clear hit the same bit in the same cycle, set wins.
  - irq = OR of the status bits, registered. Reset value 0.
- CFG_SLV_STATUS_EN undefined: there are no status_in/irq ports, and idx = pNUM_REGS is unmapped (reads 0xFFFFFFFF).

## Structure
- Package cfg_slv_pkg holds:
  - write and read FSM state enums
  - ERR_RDATA = 32'hFFFFFFFF
  - the status-slot index helper
- Sub-module cfg_slv_regfile holds the register array with byte-strobed write, the write pulses and the read mux. The top level contains the two handshake FSMs and the decode.

## Test plan
- Write 0x12345678 to offset 0x004 with wstrb = 0xF → awready/wready high together in cycle 1; reg 1 = 0x12345678 and reg_wr_pulse[1] high in cycle 2; read of 0x004 returns 0x12345678.
- wstrb = 0x2 with wdata = 0xAABBCCDD onto reg 1 = 0x12345678 → reg 1 = 0x1234CC78.
- Read offset 0x0FC (pNUM_REGS = 8) with rready held low for 5 cycles → rvalid and rdata = 0xFFFFFFFF stable for all 5 cycles; the FSM returns to R_IDLE the cycle rready rises.
- awvalid alone for 3 cycles, then wvalid → no ready while only awvalid is high; the write completes 1 cycle after wvalid rises.
- Reset asserted while the read is in R_DATA → rvalid = 0 immediately and reg_out = 0; after release, arvalid with cc_enable = 0 → no arready.
- CFG_SLV_STATUS_EN: status_in[3] pulse → read of status slot = 0x8 and irq = 1; W1C write of 0x8 in the same cycle as another status_in[3] pulse → bit stays 1.
